// File: rtl/camera_sccb_config.sv
// Loads camera registers over SCCB/I2C from an external ROM table on a rising edge of start.
// Optional macro CAMCFG_ACK_CHECK_EN: sample ACKs, abort the run and flag err on a NACK.
module camera_sccb_config #(
    parameter int unsigned CLK_HZ   = 50_000_000,
    parameter int unsigned I2C_HZ   = 100_000,
    parameter logic [6:0]  DEV_ADDR = 7'h3C,
    parameter int unsigned NUM_REGS = 256,
    parameter int unsigned AW       = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    output logic [AW-1:0] rom_addr,
    input  logic [23:0]   rom_data,
    output logic          scl_oe,
    output logic          sda_oe,
    input  logic          sda_in,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int unsigned   QDIV      = CLK_HZ / (4 * I2C_HZ);
    localparam int unsigned   TW        = (QDIV > 1) ? $clog2(QDIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(QDIV - 1);
    localparam logic [AW-1:0] IDX_LAST  = AW'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        StIdle, StFetch, StStart, StByte, StAck, StStop, StGap
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          start_d_q;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [31:0]   shift_q, shift_d;
    logic [2:0]    bit_q, bit_d;
    logic [1:0]    byte_q, byte_d;
    logic          fetch_q, fetch_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [1:0]    quarter_q, quarter_d;
    logic          scl_oe_q, scl_oe_d;
    logic          sda_oe_q, sda_oe_d;

    logic launch;
    logic timed;
    logic qend;
    logic slot_end;

`ifdef CAMCFG_ACK_CHECK_EN
    logic [1:0] sda_sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sda_sync_q <= 2'b11;
        end else begin
            sda_sync_q <= {sda_sync_q[0], sda_in};
        end
    end
`else
    logic unused_sda_in;
    assign unused_sda_in = sda_in;
`endif

    assign launch   = start & ~start_d_q;
    assign timed    = (state_q == StStart) || (state_q == StByte) || (state_q == StAck) ||
                      (state_q == StStop) || (state_q == StGap);
    assign qend     = (tick_q == TICK_LAST);
    assign slot_end = qend && (quarter_q == 2'd3);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        busy_d    = busy_q;
        done_d    = done_q;
        err_d     = err_q;
        shift_d   = shift_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        fetch_d   = fetch_q;
        tick_d    = '0;
        quarter_d = 2'd0;
        scl_oe_d  = 1'b0;
        sda_oe_d  = 1'b0;

        if (timed) begin
            tick_d    = qend ? '0 : tick_q + TW'(1);
            quarter_d = qend ? quarter_q + 2'd1 : quarter_q;
        end

        unique case (state_q)
            StIdle: begin
                if (launch) begin
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    idx_d   = '0;
                    fetch_d = 1'b0;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                // First cycle presents rom_addr; ROM data is valid on the second.
                if (!fetch_q) begin
                    fetch_d = 1'b1;
                end else begin
                    fetch_d = 1'b0;
                    shift_d = {DEV_ADDR, 1'b0, rom_data};
                    bit_d   = 3'd0;
                    byte_d  = 2'd0;
                    state_d = StStart;
                end
            end
            StStart: begin
                scl_oe_d = (quarter_q == 2'd3);
                sda_oe_d = (quarter_q != 2'd0);
                if (slot_end) begin
                    state_d = StByte;
                end
            end
            StByte: begin
                scl_oe_d = (quarter_q == 2'd0) || (quarter_q == 2'd3);
                sda_oe_d = ~shift_q[31];
                if (slot_end) begin
                    shift_d = {shift_q[30:0], 1'b0};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = StAck;
                    end
                end
            end
            StAck: begin
                scl_oe_d = (quarter_q == 2'd0) || (quarter_q == 2'd3);
`ifdef CAMCFG_ACK_CHECK_EN
                if (qend && (quarter_q == 2'd1) && sda_sync_q[1]) begin
                    err_d = 1'b1;
                end
`endif
                if (slot_end) begin
                    if ((byte_q == 2'd3) || err_q) begin
                        state_d = StStop;
                    end else begin
                        byte_d  = byte_q + 2'd1;
                        state_d = StByte;
                    end
                end
            end
            StStop: begin
                scl_oe_d = (quarter_q == 2'd0);
                sda_oe_d = (quarter_q < 2'd2);
                if (slot_end) begin
                    state_d = StGap;
                end
            end
            StGap: begin
                if (slot_end) begin
                    if ((idx_q == IDX_LAST) || err_q) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        idx_d   = idx_q + AW'(1);
                        state_d = StFetch;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            start_d_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            shift_q   <= '0;
            bit_q     <= 3'd0;
            byte_q    <= 2'd0;
            fetch_q   <= 1'b0;
            tick_q    <= '0;
            quarter_q <= 2'd0;
            scl_oe_q  <= 1'b0;
            sda_oe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            start_d_q <= start;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            shift_q   <= shift_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            fetch_q   <= fetch_d;
            tick_q    <= tick_d;
            quarter_q <= quarter_d;
            scl_oe_q  <= scl_oe_d;
            sda_oe_q  <= sda_oe_d;
        end
    end

    assign rom_addr = idx_q;
    assign scl_oe   = scl_oe_q;
    assign sda_oe   = sda_oe_q;
    assign busy     = busy_q;
    assign done     = done_q;
`ifdef CAMCFG_ACK_CHECK_EN
    assign err      = err_q;
`else
    assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_camera_sccb_config.sv
// Directed bench for camera_sccb_config: bus decoder/ACK slave model, ROM model, timing probe.
module tb_camera_sccb_config;

    localparam logic [8:0] TOK_START = 9'h100;
    localparam logic [8:0] TOK_STOP  = 9'h1FF;

    logic        clk = 1'b0;
    logic        reset_n, start;
    logic [7:0]  rom_addr;
    logic [23:0] rom_data;
    logic        scl_oe, sda_oe, sda_in, busy, done, err;

    logic        rst2_n, start2;
    logic [7:0]  rom_addr2;
    logic [23:0] rom_data2;
    logic        scl_oe2, sda_oe2, sda_in2, busy2, done2, err2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [23:0] rom [0:3];
    logic        slave_pull = 1'b0;
    int          bitn = 0, bytn = 0, tx_cnt = 0, hi_chg = 0, launches = 0;
    logic [7:0]  sh = 8'h00;
    logic        scl_prev = 1'b1, sda_prev = 1'b1, busy_prev = 1'b0;
    logic [8:0]  bus_log [$];
    bit          nack_en = 1'b0;
    int          nack_tx = 0, nack_byte = 0;

    logic [8:0] exp_full [12] = '{TOK_START, 9'h078, 9'h030, 9'h008, 9'h082, TOK_STOP,
                                  TOK_START, 9'h078, 9'h031, 9'h003, 9'h003, TOK_STOP};

    always #5 clk = ~clk;

    camera_sccb_config #(
        .CLK_HZ  (1600),
        .I2C_HZ  (100),
        .DEV_ADDR(7'h3C),
        .NUM_REGS(2),
        .AW      (8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .scl_oe  (scl_oe),
        .sda_oe  (sda_oe),
        .sda_in  (sda_in),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    camera_sccb_config dut_def (
        .clk     (clk),
        .reset_n (rst2_n),
        .start   (start2),
        .rom_addr(rom_addr2),
        .rom_data(rom_data2),
        .scl_oe  (scl_oe2),
        .sda_oe  (sda_oe2),
        .sda_in  (sda_in2),
        .busy    (busy2),
        .done    (done2),
        .err     (err2)
    );

    always @(posedge clk) rom_data <= rom[rom_addr[1:0]];
    assign sda_in    = ~(sda_oe | slave_pull);
    assign rom_data2 = 24'h3008_82;
    assign sda_in2   = ~sda_oe2;

    // Slave model: decodes START/STOP/bytes off the pads and ACKs each byte.
    always @(negedge clk) begin
        logic scl_now, sda_now;
        if (!reset_n) begin
            slave_pull = 1'b0;
            bitn       = 0;
            bytn       = 0;
            scl_prev   = 1'b1;
            sda_prev   = 1'b1;
            busy_prev  = 1'b0;
        end else begin
            scl_now = ~scl_oe;
            sda_now = sda_in;
            if (scl_prev && scl_now && (sda_prev != sda_now)) begin
                hi_chg++;
                bitn = 0;
                if (!sda_now) begin
                    bytn = 0;
                    tx_cnt++;
                    bus_log.push_back(TOK_START);
                end else begin
                    bus_log.push_back(TOK_STOP);
                end
            end else if (!scl_prev && scl_now) begin
                if (bitn < 8) sh = {sh[6:0], sda_now};
                bitn++;
            end else if (scl_prev && !scl_now) begin
                if (bitn == 8) begin
                    bus_log.push_back({1'b0, sh});
                    slave_pull = !(nack_en && ((tx_cnt - 1) == nack_tx) && (bytn == nack_byte));
                end else if (bitn == 9) begin
                    slave_pull = 1'b0;
                    bitn       = 0;
                    bytn++;
                end
            end
            scl_prev = scl_now;
            sda_prev = sda_now;
            if (busy && !busy_prev) launches++;
            busy_prev = busy;
        end
    end

    task automatic clear_bus();
        bus_log.delete();
        tx_cnt   = 0;
        hi_chg   = 0;
        launches = 0;
        nack_en  = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk);
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (!busy && done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (rom_addr !== 8'h00) begin n_fail++; $display("FAIL reset_rom_addr: got %0h want 0", rom_addr); end
        n_checks++; if (scl_oe !== 1'b0) begin n_fail++; $display("FAIL reset_scl_oe: got %b want 0", scl_oe); end
        n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_two_entries();
        bit ok;
        clear_bus();
        pulse_start();
        n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL launch_flags: busy=%b done=%b want busy=1 done=0", busy, done); end
        wait_done(4000, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL two_done: busy=%b done=%b want busy=0 done=1", busy, done); end
        n_checks++; if (bus_log.size() != 12) begin n_fail++; $display("FAIL two_len: got %0d want 12", bus_log.size()); end
        for (int i = 0; i < 12 && i < bus_log.size(); i++) begin
            n_checks++;
            if (bus_log[i] !== exp_full[i]) begin n_fail++; $display("FAIL two_tok%0d: got %0h want %0h", i, bus_log[i], exp_full[i]); end
        end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL two_err: got %b want 0", err); end
        n_checks++; if (hi_chg != 4) begin n_fail++; $display("FAIL sda_while_scl_high: got %0d changes want 4", hi_chg); end
    endtask

    task automatic test_scl_timing();
        int n;
        bit found;
        rst2_n = 1'b1;
        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (scl_oe2) begin found = 1'b1; break; end
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL scl_first_low: got none want scl_oe=1"); end
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (scl_oe2 == 1'b1 && n < 2000) begin n++; @(negedge clk); end
            n_checks++; if (n != 250) begin n_fail++; $display("FAIL scl_low%0d: got %0d want 250", k, n); end
            n = 0;
            while (scl_oe2 == 1'b0 && n < 2000) begin n++; @(negedge clk); end
            n_checks++; if (n != 250) begin n_fail++; $display("FAIL scl_high%0d: got %0d want 250", k, n); end
        end
        rst2_n = 1'b0;
    endtask

    task automatic test_nack();
        bit ok;
        logic [8:0] exp_nack [4];
        exp_nack = '{TOK_START, 9'h078, 9'h030, TOK_STOP};
        clear_bus();
`ifdef CAMCFG_ACK_CHECK_EN
        nack_en   = 1'b1;
        nack_tx   = 0;
        nack_byte = 1;
`endif
        pulse_start();
        wait_done(4000, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL nack_done: busy=%b done=%b want busy=0 done=1", busy, done); end
`ifdef CAMCFG_ACK_CHECK_EN
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL nack_err: got %b want 1", err); end
        n_checks++; if (bus_log.size() != 4) begin n_fail++; $display("FAIL nack_len: got %0d want 4", bus_log.size()); end
        for (int i = 0; i < 4 && i < bus_log.size(); i++) begin
            n_checks++;
            if (bus_log[i] !== exp_nack[i]) begin n_fail++; $display("FAIL nack_tok%0d: got %0h want %0h", i, bus_log[i], exp_nack[i]); end
        end
`else
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL noack_err: got %b want 0", err); end
        n_checks++; if (bus_log.size() != 12) begin n_fail++; $display("FAIL noack_len: got %0d want 12 (head %0h)", bus_log.size(), exp_nack[0]); end
`endif
        nack_en = 1'b0;
    endtask

    task automatic test_held_start();
        bit ok;
        clear_bus();
        @(negedge clk) start = 1'b1;
        repeat (13000) @(negedge clk);
        n_checks++; if (launches != 1) begin n_fail++; $display("FAIL held_runs: got %0d want 1", launches); end
        n_checks++; if (busy !== 1'b0 || done !== 1'b1) begin n_fail++; $display("FAIL held_idle: busy=%b done=%b want busy=0 done=1", busy, done); end
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL relaunch_flags: busy=%b done=%b want busy=1 done=0", busy, done); end
        start = 1'b0;
        wait_done(4000, ok);
        n_checks++; if (!ok || launches != 2) begin n_fail++; $display("FAIL relaunch_runs: ok=%b runs=%0d want ok=1 runs=2", ok, launches); end
        n_checks++; if (bus_log.size() != 24) begin n_fail++; $display("FAIL relaunch_len: got %0d want 24", bus_log.size()); end
    endtask

    task automatic test_repulse();
        bit ok;
        clear_bus();
        pulse_start();
        repeat (200) @(negedge clk);
        n_checks++; if (busy !== 1'b1 || rom_addr !== 8'h00) begin n_fail++; $display("FAIL repulse_pre: busy=%b addr=%0h want busy=1 addr=0", busy, rom_addr); end
        pulse_start();
        wait_done(4000, ok);
        n_checks++; if (!ok || launches != 1) begin n_fail++; $display("FAIL repulse_runs: ok=%b runs=%0d want ok=1 runs=1", ok, launches); end
        n_checks++; if (bus_log.size() != 12) begin n_fail++; $display("FAIL repulse_len: got %0d want 12", bus_log.size()); end
        repeat (700) @(negedge clk);
        n_checks++; if (busy !== 1'b0 || launches != 1) begin n_fail++; $display("FAIL repulse_quiet: busy=%b runs=%0d want busy=0 runs=1", busy, launches); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit found;
        clear_bus();
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (bytn == 1 && bitn == 3 && scl_oe) begin found = 1'b1; break; end
        end
        repeat (6) @(negedge clk);
        n_checks++; if (!found || scl_oe !== 1'b1) begin n_fail++; $display("FAIL mid_pre: found=%b scl_oe=%b want 1,1", found, scl_oe); end
        reset_n = 1'b0;
        #1;
        n_checks++; if (scl_oe !== 1'b0 || sda_oe !== 1'b0) begin n_fail++; $display("FAIL mid_lines: scl_oe=%b sda_oe=%b want 0,0", scl_oe, sda_oe); end
        n_checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || rom_addr !== 8'h00) begin
            n_fail++; $display("FAIL mid_outs: busy=%b done=%b err=%b addr=%0h want 0,0,0,0", busy, done, err, rom_addr);
        end
        @(negedge clk) reset_n = 1'b1;
        clear_bus();
        @(negedge clk);
        pulse_start();
        n_checks++; if (rom_addr !== 8'h00 || busy !== 1'b1) begin n_fail++; $display("FAIL mid_restart: addr=%0h busy=%b want 0,1", rom_addr, busy); end
        wait_done(4000, ok);
        n_checks++; if (!ok || bus_log.size() != 12) begin n_fail++; $display("FAIL mid_rerun: ok=%b len=%0d want 1,12", ok, bus_log.size()); end
        for (int i = 0; i < 5 && i < bus_log.size(); i++) begin
            n_checks++;
            if (bus_log[i] !== exp_full[i]) begin n_fail++; $display("FAIL mid_tok%0d: got %0h want %0h", i, bus_log[i], exp_full[i]); end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rom[0] = 24'h3008_82;
        rom[1] = 24'h3103_03;
        rom[2] = 24'h0000_00;
        rom[3] = 24'h0000_00;
        start  = 1'b0;
        start2 = 1'b0;
        rst2_n = 1'b0;
        test_reset();
        test_two_entries();
        test_scl_timing();
        test_nack();
        test_held_start();
        test_repulse();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
